// File: rtl/multi_ch_grant_arbiter.sv
// multi_ch_grant_arbiter: round-robin single-grant arbiter with ack/abort/timeout release and sticky timeout irqs; ports req_i/ack_i/irq_clr_i in, gnt_o/gnt_id_o/busy_o/irq_o/irq_any_o out
module multi_ch_grant_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [NUM_CH-1:0]         ack_i,
  input  logic [NUM_CH-1:0]         irq_clr_i,
  output logic [NUM_CH-1:0]         gnt_o,
  output logic [$clog2(NUM_CH)-1:0] gnt_id_o,
  output logic                      busy_o,
  output logic [NUM_CH-1:0]         irq_o,
  output logic                      irq_any_o
);
  localparam int ID_W = $clog2(NUM_CH);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t            state_q, state_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d, irq_q, irq_d;
  logic [ID_W-1:0]   id_q, id_d, last_q, last_d, sel;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              irq_any_q, hit, start, expire, rel, tmo;
  // descending scan so the nearest requester after last_q is the final assignment
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int k = NUM_CH; k >= 1; k--)
      if (req_i[(int'(last_q) + k) % NUM_CH]) begin
        sel = ID_W'((int'(last_q) + k) % NUM_CH);
        hit = 1'b1;
      end
  end
  always_comb begin
    start   = state_q == IDLE && hit;
    expire  = cnt_q == CNT_W'(TIMEOUT - 1);
    rel     = state_q == GRANT && (ack_i[id_q] || !req_i[id_q] || expire);
    tmo     = state_q == GRANT && !ack_i[id_q] && req_i[id_q] && expire;
    state_d = start ? GRANT : rel ? IDLE : state_q;
    gnt_d   = start ? NUM_CH'(1) << sel : rel ? '0 : gnt_q;
    id_d    = start ? sel : id_q;
    last_d  = rel ? id_q : last_q;
    cnt_d   = start ? '0 : state_q == GRANT ? cnt_q + 1'b1 : cnt_q;
    irq_d   = (irq_q & ~irq_clr_i) | (tmo ? NUM_CH'(1) << id_q : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      last_q    <= ID_W'(NUM_CH - 1);
      cnt_q     <= '0;
      irq_q     <= '0;
      irq_any_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
      irq_any_q <= |irq_d;
    end
  end
  assign gnt_o     = gnt_q;
  assign gnt_id_o  = id_q;
  assign busy_o    = state_q == GRANT;
  assign irq_o     = irq_q;
  assign irq_any_o = irq_any_q;
  a_onehot: assert property (@(posedge clk) $onehot0(gnt_q));
endmodule

// File: tb/tb_multi_ch_grant_arbiter.sv
// tb_multi_ch_grant_arbiter: table vectors, corner sequences and random stimulus against a reference model
module tb_multi_ch_grant_arbiter;
  localparam int T = 5;
  logic       clk = 0, rst = 0;
  logic [3:0] req = 0, ack = 0, clr = 0, gnt, irq;
  logic [1:0] gnt_id;
  logic       busy, irq_any;
  int         pass = 0, total = 0;
  int         m_g = -1, m_held = 0, m_last = 3;
  logic [3:0] m_irq = 0;
  typedef struct {
    logic [3:0] req, ack, clr;
    logic       rst;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic [3:0] irq;
  } vec_t;
  vec_t vq[$];
  multi_ch_grant_arbiter #(.NUM_CH(4), .CNT_W(8), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req_i(req), .ack_i(ack), .irq_clr_i(clr),
    .gnt_o(gnt), .gnt_id_o(gnt_id), .busy_o(busy), .irq_o(irq), .irq_any_o(irq_any)
  );
  always #5 clk = ~clk;
  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", n, got, exp);
    else pass++;
  endtask
  // channel held, cycles completed, last served, sticky flags
  task automatic model_step(input logic [3:0] r, input logic [3:0] a, input logic [3:0] c, input logic rs);
    logic [3:0] set;
    bit found;
    set = 0;
    found = 0;
    if (rs) begin
      m_g = -1; m_held = 0; m_last = 3; m_irq = 0;
    end else begin
      if (m_g < 0) begin
        for (int k = 1; k <= 4; k++)
          if (!found && r[(m_last + k) % 4]) begin
            m_g = (m_last + k) % 4; m_held = 0; found = 1;
          end
      end else if (a[m_g] || !r[m_g]) begin
        m_last = m_g; m_g = -1;
      end else if (m_held + 1 == T) begin
        set[m_g] = 1; m_last = m_g; m_g = -1;
      end else m_held++;
      m_irq = (m_irq & ~c) | set;
    end
  endtask
  task automatic cyc(input logic [3:0] r, input logic [3:0] a, input logic [3:0] c, input logic rs);
    logic [3:0] eg;
    req = r; ack = a; clr = c; rst = rs;
    @(posedge clk);
    model_step(r, a, c, rs);
    #1;
    eg = m_g < 0 ? 4'b0 : 4'(1 << m_g);
    check("model_outputs", {gnt, busy, irq, irq_any}, {eg, m_g >= 0, m_irq, |m_irq});
    if (m_g >= 0) check("model_gnt_id", 32'(gnt_id), 32'(m_g));
  endtask
  initial begin
    vec_t v;
    vq.push_back('{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000});
    vq.push_back('{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000});
    vq.push_back('{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000});
    vq.push_back('{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000});
    vq.push_back('{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000});
    vq.push_back('{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000});
    for (int i = 0; i < 5; i++) begin
      vq.push_back('{4'b1111, 4'b0000, 4'b0000, 1'b0, 4'(1 << (i % 4)), 2'(i % 4), 1'b1, 4'b0000});
      vq.push_back('{4'b1111, 4'(1 << (i % 4)), 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000});
    end
    vq.push_back('{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000});
    for (int i = 0; i < T; i++)
      vq.push_back('{4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000});
    vq.push_back('{4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0010});
    vq.push_back('{4'b0000, 4'b0000, 4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000});
    vq.push_back('{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000});
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      cyc(v.req, v.ack, v.clr, v.rst);
      check($sformatf("vec%0d", i), {gnt, busy, irq, irq_any}, {v.gnt, v.busy, v.irq, |v.irq});
      if (v.busy) check($sformatf("vec%0d_id", i), 32'(gnt_id), 32'(v.id));
    end
    cyc(4'b0010, 0, 0, 0);
    repeat (T - 1) cyc(4'b0010, 0, 0, 0);
    cyc(4'b0010, 4'b0010, 0, 0);
    check("ack_wins_last_cycle", {gnt, irq}, 8'h00);
    repeat (T + 1) cyc(4'b0010, 0, 0, 0);
    check("timeout_irq", 32'(irq), 32'h2);
    repeat (T) cyc(4'b0010, 0, 0, 0);
    cyc(4'b0010, 0, 4'b0010, 0);
    check("set_beats_clear", {gnt, irq, 3'b0, irq_any}, {4'b0000, 4'b0010, 4'b0001});
    cyc(0, 0, 4'b0010, 1);
    cyc(4'b1000, 0, 0, 0);
    check("grant_ch3", 32'(gnt), 32'h8);
    cyc(4'b1000, 4'b0001, 0, 0);
    check("spurious_ack", {gnt, 2'b0, gnt_id}, {4'b1000, 4'b0011});
    cyc(4'b0111, 0, 0, 0);
    check("abort", {gnt, irq}, 8'h00);
    cyc(4'b0111, 0, 0, 0);
    check("after_abort_ch0", {gnt, 2'b0, gnt_id}, {4'b0001, 4'b0000});
    cyc(0, 0, 0, 0);
    cyc(4'b0010, 0, 0, 0);
    check("grant_ch1", 32'(gnt), 32'h2);
    cyc(4'b1111, 0, 0, 1);
    check("reset_mid_grant", {gnt, busy, irq, irq_any}, 10'h0);
    cyc(4'b1111, 0, 0, 0);
    check("post_reset_ch0", {gnt, 2'b0, gnt_id}, {4'b0001, 4'b0000});
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      r = $urandom_range(0, 3) == 0 ? 4'($urandom) : req;
      cyc(r, $urandom_range(0, 5) == 0 ? 4'($urandom) : 4'b0,
          $urandom_range(0, 9) == 0 ? 4'($urandom) : 4'b0, $urandom_range(0, 199) == 0);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
